// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential radix-4 Booth multiplier between NUM_REQ clients.
// Latency: product on resp_* MUL_LAT+2 edges after the accept edge (1 edge with zero bypass).
// Backpressure: one job in flight; req_ready stays low until resp_ready drains the held product.
// Optional feature macro: MULT_ARB_ZERO_BYPASS_EN (zero operand skips the multiplier).
module booth_mult_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int MUL_LAT = 17,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_in1,
  input  logic [NUM_REQ*32-1:0] req_in2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_result,
  output logic                  mul_start,
  output logic [31:0]           mul_in1,
  output logic [31:0]           mul_in2,
  input  logic [63:0]           mul_result,
  output logic                  busy
);

  // Counter must reach MUL_LAT and take one more increment on the capture edge.
  localparam int CNT_W = $clog2(MUL_LAT + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [63:0]       r_resp_result;
  logic              r_mul_start;
  logic [31:0]       r_mul_in1;
  logic [31:0]       r_mul_in2;

  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  int                w_idx;
  logic [31:0]       w_gnt_in1;
  logic [31:0]       w_gnt_in2;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic              w_zero;
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'(w_idx);
      end
    end
  end

  assign w_gnt_in1 = req_in1[32*w_gnt +: 32];
  assign w_gnt_in2 = req_in2[32*w_gnt +: 32];
`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign w_zero    = (w_gnt_in1 == 32'd0) || (w_gnt_in2 == 32'd0);
`endif

  // Grant is offered only while idle; at most one bit set.
  assign req_ready = (r_state == IDLE && w_found) ? (NUM_REQ'(1) << w_gnt) : '0;

  // Job sequencer: accept, pulse start, count out the multiplier latency, hold product until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_mul_start   <= 1'b0;
      r_mul_in1     <= '0;
      r_mul_in2     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_mul_in1 <= w_gnt_in1;
            r_mul_in2 <= w_gnt_in2;
            r_resp_id <= w_gnt;
            if (w_gnt == ID_W'(NUM_REQ - 1)) r_rr_ptr <= '0;
            else                             r_rr_ptr <= w_gnt + 1'b1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
            if (w_zero) begin
              // Product is known to be zero; never wake the multiplier.
              r_resp_result <= '0;
              r_resp_valid  <= 1'b1;
              r_state       <= RESP;
            end else begin
              r_mul_start <= 1'b1;
              r_state     <= LOAD;
            end
`else
            r_mul_start <= 1'b1;
            r_state     <= LOAD;
`endif
          end
        end
        LOAD: begin
          r_mul_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          // Core has no done flag: the final product is trusted purely by edge count.
          if (r_cnt == CNT_W'(MUL_LAT)) begin
            r_resp_result <= mul_result;
            r_resp_valid  <= 1'b1;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign mul_start   = r_mul_start;
  assign mul_in1     = r_mul_in1;
  assign mul_in2     = r_mul_in2;
  assign busy        = (r_state != IDLE);

endmodule
